// File: rtl/rr_reg_arbiter.sv
// Round-robin write arbiter in front of a single shared WIDTH-bit register.
// One requester word is loaded per cycle. A requester can lock the register
// for a burst, and the lock is released after LOCK_MAX cycles without a transfer.
// Handshake: a word moves when req_valid[i] & req_ready[i] is high at a rising
// edge. req_ready is one-hot or zero. It depends only on state, sclr, rst_n and
// req_valid, and never on req_data. A requester holds valid/data/lock stable
// until it sees ready.
module rr_reg_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 3,
  parameter int LOCK_MAX = 8,
  parameter int IDW      = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sclr,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]       req_lock,
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       q,
  output logic                   q_upd,
  output logic [IDW-1:0]         q_src,
  output logic                   locked
);

  localparam int              CNTW     = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [IDW-1:0]  LAST_IDX = IDW'(N_REQ - 1);
  localparam logic [IDW:0]    N_REQ_W  = (IDW + 1)'(N_REQ);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(LOCK_MAX - 1);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [CNTW-1:0]  lock_cnt_q, lock_cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_upd_q, q_upd_d;
  logic [IDW-1:0]   q_src_q, q_src_d;

  logic [IDW:0]     scan_sum;
  logic [IDW-1:0]   scan_idx;
  logic [IDW-1:0]   win_idx;
  logic             win_found;
  logic             xfer;
  logic [IDW-1:0]   xfer_idx;
  logic [WIDTH-1:0] xfer_word;
  logic             xfer_lock;

  // Wraps a requester index modulo N_REQ (N_REQ may not be a power of two).
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
    next_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // Round-robin search: the first valid requester at or after ptr, wrapping.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (IDW + 1)'(k);
      if (scan_sum >= N_REQ_W) scan_sum = scan_sum - N_REQ_W;
      scan_idx = scan_sum[IDW-1:0];
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Grant. Only the owner may be granted during a lock. No grant during sclr or reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && !sclr) begin
      if (state_q == ST_LOCK) req_ready[owner_q] = req_valid[owner_q];
      else if (win_found)     req_ready[win_idx] = 1'b1;
    end
  end

  // Select the transferring requester's word and lock request.
  always_comb begin
    xfer      = |(req_valid & req_ready);
    xfer_idx  = (state_q == ST_LOCK) ? owner_q : win_idx;
    xfer_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (xfer_idx == IDW'(i)) xfer_word = req_data[i*WIDTH +: WIDTH];
    end
    xfer_lock = req_lock[xfer_idx];
  end

  // Next-state logic for the register, pointer and lock FSM.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    q_d        = q_q;
    q_upd_d    = 1'b0;
    q_src_d    = q_src_q;
    if (sclr) begin
      // Clear takes priority over everything. ptr and q_src are kept.
      q_d        = '0;
      state_d    = ST_ARB;
      lock_cnt_d = '0;
    end else begin
      if (xfer) begin
        q_d     = xfer_word;
        q_upd_d = 1'b1;
        q_src_d = xfer_idx;
        ptr_d   = next_idx(xfer_idx);
      end
      case (state_q)
        ST_ARB: begin
          if (xfer && xfer_lock) begin
            state_d    = ST_LOCK;
            owner_d    = xfer_idx;
            lock_cnt_d = '0;
          end
        end
        ST_LOCK: begin
          if (xfer) begin
            // Re-lock restarts the timeout. An unlocked transfer ends the burst.
            state_d    = xfer_lock ? ST_LOCK : ST_ARB;
            lock_cnt_d = '0;
          end else if (lock_cnt_q == CNT_LAST) begin
            state_d    = ST_ARB;
            ptr_d      = next_idx(owner_q);
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_ARB;
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ARB;
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      q_q        <= '0;
      q_upd_q    <= 1'b0;
      q_src_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      q_q        <= q_d;
      q_upd_q    <= q_upd_d;
      q_src_q    <= q_src_d;
    end
  end

  assign q      = q_q;
  assign q_upd  = q_upd_q;
  assign q_src  = q_src_q;
  assign locked = (state_q == ST_LOCK);

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Self-checking bench for rr_reg_arbiter with N_REQ=4, WIDTH=3, LOCK_MAX=8.
module tb_rr_reg_arbiter;

  localparam int N_REQ    = 4;
  localparam int WIDTH    = 3;
  localparam int LOCK_MAX = 8;
  localparam int IDW      = 2;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   sclr;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_lock;
  logic [N_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]       q;
  logic                   q_upd;
  logic [IDW-1:0]         q_src;
  logic                   locked;

  rr_reg_arbiter #(
    .N_REQ(N_REQ), .WIDTH(WIDTH), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclr(sclr),
    .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
    .req_ready(req_ready), .q(q), .q_upd(q_upd), .q_src(q_src), .locked(locked)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Counters and the scoreboard queue of words expected to land in q.
  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [N_REQ-1:0] act_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model. It is stated in terms of ownership and lock age, and it
  // uses modular arithmetic for the round-robin order.
  logic [WIDTH-1:0] m_q;
  logic             m_upd;
  int               m_src, m_ptr, m_owner, m_age;
  bit               m_lock;

  task automatic model_reset();
    m_q = '0; m_upd = 1'b0; m_src = 0; m_ptr = 0; m_owner = 0; m_age = 0; m_lock = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [N_REQ-1:0] model_ready(input logic [N_REQ-1:0] v, input logic s);
    logic [N_REQ-1:0] r;
    r = '0;
    if (s) return r;
    if (m_lock) begin
      r[m_owner] = v[m_owner];
      return r;
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (v[(m_ptr + k) % N_REQ]) begin
        r[(m_ptr + k) % N_REQ] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_step(input logic [N_REQ-1:0] v, input logic [N_REQ*WIDTH-1:0] d,
                            input logic [N_REQ-1:0] l, input logic s,
                            input logic [N_REQ-1:0] r);
    int who;
    if (s) begin
      m_q = '0; m_upd = 1'b0; m_lock = 1'b0; m_age = 0;
      return;
    end
    who = -1;
    for (int i = 0; i < N_REQ; i++) if (v[i] && r[i]) who = i;
    m_upd = (who >= 0);
    if (who >= 0) begin
      m_q    = d[who*WIDTH +: WIDTH];
      m_src  = who;
      m_ptr  = (who + 1) % N_REQ;
      m_lock = l[who];
      if (l[who]) begin
        m_owner = who;
        m_age   = 0;
      end
      exp_q.push_back(m_q);
    end else if (m_lock) begin
      if (m_age == LOCK_MAX - 1) begin
        m_lock = 1'b0;
        m_age  = 0;
        m_ptr  = (m_owner + 1) % N_REQ;
      end else begin
        m_age++;
      end
    end
  endtask

  // Driver: apply one cycle of inputs, check the grant, clock it, check the outputs.
  task automatic step(input logic [N_REQ-1:0] v, input logic [N_REQ*WIDTH-1:0] d,
                      input logic [N_REQ-1:0] l, input logic s);
    logic [N_REQ-1:0] er;
    @(negedge clk);
    req_valid = v; req_data = d; req_lock = l; sclr = s;
    #1;
    er = model_ready(v, s);
    act_ready = req_ready;
    check("req_ready", req_ready, er);
    @(posedge clk);
    model_step(v, d, l, s, er);
    #1;
    check("q", q, m_q);
    check("q_upd", q_upd, m_upd);
    check("q_src", q_src, m_src);
    check("locked", locked, m_lock);
    if (q_upd) begin
      check("sb depth", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("sb word", q, exp_q.pop_front());
    end
  endtask

  typedef struct {
    logic [N_REQ-1:0]       valid;
    logic [N_REQ*WIDTH-1:0] data;
    logic [N_REQ-1:0]       lock;
    logic [N_REQ-1:0]       exp_ready;
    logic [WIDTH-1:0]       exp_q;
    logic                   exp_upd;
    logic [IDW-1:0]         exp_src;
    logic                   exp_locked;
  } vec_t;

  localparam logic [11:0] D_ROT = {3'd4, 3'd3, 3'd2, 3'd1};
  localparam logic [11:0] D_R2  = {3'd0, 3'd5, 3'd0, 3'd0};
  localparam logic [11:0] D_L1  = {3'd0, 3'd0, 3'd6, 3'd0};
  localparam logic [11:0] D_03  = {3'd1, 3'd0, 3'd0, 3'd7};
  localparam logic [11:0] D_13  = {3'd1, 3'd0, 3'd2, 3'd7};
  localparam logic [11:0] D_T   = {3'd0, 3'd0, 3'd7, 3'd3};

  vec_t vecs[13];

  initial begin
    // Rotation with all four valid, single-requester load, lock by req 1.
    vecs[0]  = '{4'b1111, D_ROT, 4'b0000, 4'b0001, 3'd1, 1'b1, 2'd0, 1'b0};
    vecs[1]  = '{4'b1111, D_ROT, 4'b0000, 4'b0010, 3'd2, 1'b1, 2'd1, 1'b0};
    vecs[2]  = '{4'b1111, D_ROT, 4'b0000, 4'b0100, 3'd3, 1'b1, 2'd2, 1'b0};
    vecs[3]  = '{4'b1111, D_ROT, 4'b0000, 4'b1000, 3'd4, 1'b1, 2'd3, 1'b0};
    vecs[4]  = '{4'b1111, D_ROT, 4'b0000, 4'b0001, 3'd1, 1'b1, 2'd0, 1'b0};
    vecs[5]  = '{4'b0100, D_R2,  4'b0000, 4'b0100, 3'd5, 1'b1, 2'd2, 1'b0};
    vecs[6]  = '{4'b0000, D_R2,  4'b0000, 4'b0000, 3'd5, 1'b0, 2'd2, 1'b0};
    vecs[7]  = '{4'b0010, D_L1,  4'b0010, 4'b0010, 3'd6, 1'b1, 2'd1, 1'b1};
    vecs[8]  = '{4'b1001, D_03,  4'b0000, 4'b0000, 3'd6, 1'b0, 2'd1, 1'b1};
    vecs[9]  = '{4'b1001, D_03,  4'b0000, 4'b0000, 3'd6, 1'b0, 2'd1, 1'b1};
    vecs[10] = '{4'b1001, D_03,  4'b0000, 4'b0000, 3'd6, 1'b0, 2'd1, 1'b1};
    vecs[11] = '{4'b1011, D_13,  4'b0000, 4'b0010, 3'd2, 1'b1, 2'd1, 1'b0};
    vecs[12] = '{4'b1001, D_13,  4'b0000, 4'b1000, 3'd1, 1'b1, 2'd3, 1'b0};

    // Reset state, with requests pending while reset is held.
    rst_n = 1'b0; sclr = 1'b0; req_valid = 4'b1111; req_data = D_ROT; req_lock = '0;
    model_reset();
    #3;
    check("reset ready", req_ready, 4'b0000);
    check("reset q", q, 3'd0);
    check("reset q_upd", q_upd, 1'b0);
    check("reset q_src", q_src, 2'd0);
    check("reset locked", locked, 1'b0);
    req_valid = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].valid, vecs[i].data, vecs[i].lock, 1'b0);
      check($sformatf("vec%0d ready", i), act_ready, vecs[i].exp_ready);
      check($sformatf("vec%0d q", i), q, vecs[i].exp_q);
      check($sformatf("vec%0d q_upd", i), q_upd, vecs[i].exp_upd);
      check($sformatf("vec%0d q_src", i), q_src, vecs[i].exp_src);
      check($sformatf("vec%0d locked", i), locked, vecs[i].exp_locked);
    end

    // Lock timeout: req 0 locks and goes idle while req 1 waits.
    step(4'b0001, {3'd0, 3'd0, 3'd0, 3'd3}, 4'b0001, 1'b0);
    check("to lock ready", act_ready, 4'b0001);
    check("to lock locked", locked, 1'b1);
    for (int k = 0; k < LOCK_MAX; k++) begin
      step(4'b0010, D_T, 4'b0010, 1'b0);
      check($sformatf("to cyc%0d ready", k), act_ready, 4'b0000);
      check($sformatf("to cyc%0d locked", k), locked, (k < LOCK_MAX - 1) ? 1'b1 : 1'b0);
    end
    step(4'b0010, D_T, 4'b0010, 1'b0);
    check("to grant ready", act_ready, 4'b0010);
    check("to grant q", q, 3'd7);
    check("to grant locked", locked, 1'b1);

    // sclr while req 1 holds the lock and q=7.
    step(4'b0010, D_T, 4'b0010, 1'b1);
    check("sclr ready", act_ready, 4'b0000);
    check("sclr q", q, 3'd0);
    check("sclr locked", locked, 1'b0);
    check("sclr q_src", q_src, 2'd1);
    check("sclr q_upd", q_upd, 1'b0);

    // Asynchronous reset in the middle of a lock with traffic.
    step(4'b0100, {3'd0, 3'd5, 3'd0, 3'd0}, 4'b0100, 1'b0);
    check("ar lock ready", act_ready, 4'b0100);
    step(4'b1101, {3'd1, 3'd6, 3'd0, 3'd2}, 4'b0100, 1'b0);
    check("ar relock q", q, 3'd6);
    check("ar relock locked", locked, 1'b1);
    @(negedge clk);
    req_valid = 4'b1111; req_lock = 4'b0100;
    #2 rst_n = 1'b0;
    #1;
    check("ar ready", req_ready, 4'b0000);
    check("ar q", q, 3'd0);
    check("ar locked", locked, 1'b0);
    check("ar q_upd", q_upd, 1'b0);
    check("ar q_src", q_src, 2'd0);
    model_reset();
    req_valid = '0; req_lock = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(4'b1111, D_ROT, 4'b0000, 1'b0);
    check("ar priority ready", act_ready, 4'b0001);
    check("ar priority q", q, 3'd1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic [N_REQ-1:0] rv, rl;
      logic [N_REQ*WIDTH-1:0] rd;
      logic rs;
      rv = 4'($urandom_range(0, 15));
      rd = 12'($urandom);
      rl = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if ($urandom_range(0, 4) == 0) rv = 4'b0000;
      rs = ($urandom_range(0, 39) == 0);
      step(rv, rd, rl, rs);
    end

    check("sb drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_reg_arbiter.md
Name: rr_reg_arbiter

Overview:
Round-robin write arbiter that shares a single WIDTH-bit register (asynchronous-reset flop bank) among N_REQ requesters.
- Each requester presents a word with a valid/ready handshake; exactly one word is loaded per cycle.
- A requester may lock the register for a multi-cycle burst, bounded by a timeout.
- Sits in front of shared configuration/state flops that several sequential processes must update.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 3, width of the shared register and of each request word.
- LOCK_MAX, 8, maximum consecutive cycles a lock may be held before forced release (>=1).
- IDW, $clog2(N_REQ), width of requester index (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- sclr  input  1  synchronous clear of register and lock.
- req_valid  input  N_REQ  per-requester write request.
- req_data  input  N_REQ*WIDTH  request words; requester i at [i*WIDTH +: WIDTH].
- req_lock  input  N_REQ  hold grant after this transfer.
- req_ready  output  N_REQ  one-hot-or-zero grant; combinational from state and req_valid.
- q  output  WIDTH  shared register contents.
- q_upd  output  1  one-cycle pulse: q loaded on the previous edge.
- q_src  output  IDW  index of the requester that last loaded q.
- locked  output  1  lock currently held.

Behaviour:
- Reset (rst_n low, asynchronous):
  - q=0, q_upd=0, q_src=0, locked=0.
  - Internal round-robin pointer ptr=0, lock owner=0, lock_cnt=0, state ARB.
  - req_ready=0 while rst_n is low.
- States: ARB, LOCK.
- ARB:
  - Winner is the first i with req_valid[i]=1, searching ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
  - req_ready[winner]=1; all other ready bits are 0. No valid means req_ready=0.
- Transfer occurs when req_valid[i] & req_ready[i]. At the next edge:
  - q<=word i, q_src<=i, q_upd<=1, ptr<=(i+1) mod N_REQ.
  - If req_lock[i]=1: state<=LOCK, owner<=i, lock_cnt<=0.
- No transfer: q holds, q_upd<=0, ptr holds.
- LOCK:
  - req_ready[owner]=req_valid[owner]; all other ready bits are 0, even when they are valid.
  - lock_cnt increments every cycle in LOCK.
  - A transfer from the owner with req_lock=0 returns to ARB. ptr=owner+1.
  - A transfer with req_lock=1 stays in LOCK and resets lock_cnt to 0.
  - Timeout: when lock_cnt reaches LOCK_MAX-1 without a transfer, the next edge forces ARB with ptr=owner+1. Owner ready is still granted in that final cycle.
  - A transfer in the timeout cycle completes normally. If it carries req_lock=1 it re-locks.
- locked=1 exactly when state==LOCK.
- sclr (priority over everything):
  - req_ready=0 in the sclr cycle.
  - Next edge: q<=0, q_upd<=0, state<=ARB, lock_cnt<=0.
  - ptr and q_src hold.
- Requesters must hold valid/data/lock stable until ready. Ready never depends on req_data.
- Throughput: one transfer per cycle sustained. Latency: valid&ready to q visible is one edge.
- Reset asserted mid-lock clears everything immediately; no partial state survives.
- Out-of-range ptr is unreachable; wrap uses modulo N_REQ for non-power-of-2 N_REQ.

Test Plan:
- Reset, then all four valid every cycle, req_lock=0:
  - Grants rotate 0,1,2,3,0.
  - q follows each word one edge later.
  - q_upd stays high continuously.
- Only req 2 valid with data 3'b101:
  - req_ready=4'b0100 in the same cycle.
  - Next cycle q=5, q_src=2, q_upd=1.
  - Following cycle q_upd=0 and q holds 5.
- Req 1 transfers with req_lock=1, then req 0 and req 3 are valid for 3 cycles:
  - locked=1; only req_ready[1] can assert.
  - Req 1 then transfers with lock=0, giving locked=0 and ptr=2, so req 3 wins next.
- Lock held by req 0 with no further valid, LOCK_MAX=8:
  - Forced release after 8 LOCK cycles.
  - Req 1 pending is granted in cycle 9.
- sclr pulse while locked with q=3'b111:
  - req_ready=0 that cycle.
  - Next cycle q=0, locked=0, q_src unchanged.
- rst_n dropped asynchronously mid-cycle during a lock with traffic:
  - q=0, locked=0, req_ready=0 immediately.
  - After release, req 0 has first priority.
